// File: rtl/alarm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : alarm_input_conditioner
// Description : Synchronises and debounces the panic/arm keys into single-cycle
//               press pulses and conditions three zone sensor levels.
//               Optional macro ZONE_DEBOUNCE_EN adds per-bit zone debouncing.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_input_conditioner #(
    parameter int DB_CYCLES = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iKEY_PANIC,
    input  logic       iKEY_ARM,
    input  logic [2:0] iZONE,
    output logic       panic_key,
    output logic       arm_key,
    output logic [2:0] zone_sensor
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic [3:0] C_DB = 4'(DB_CYCLES);

    // Key index 0 = panic, 1 = arm; keys are active-low so they reset released.
    logic [1:0] r_key_s1, r_key_s2;
    logic [2:0] r_zone_s1, r_zone_s2;
    logic [1:0] w_key_evt;
    logic [2:0] w_zone_next;
    logic       r_panic_key, r_arm_key;
    logic [2:0] r_zone_out;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_key_s1  <= 2'b11;
            r_key_s2  <= 2'b11;
            r_zone_s1 <= 3'b000;
            r_zone_s2 <= 3'b000;
        end else begin
            r_key_s1  <= {iKEY_ARM, iKEY_PANIC};
            r_key_s2  <= r_key_s1;
            r_zone_s1 <= iZONE;
            r_zone_s2 <= r_zone_s1;
        end
    end

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            key_state_t r_state, w_state_nxt;
            logic [3:0] r_cnt, w_cnt_nxt;
            logic       w_pressed;
            logic       w_evt;

            assign w_pressed = ~r_key_s2[k];

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // Counter never exceeds DB_CYCLES-1 before a transition, so +1 cannot wrap.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_evt       = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_pressed) begin
                            w_state_nxt = ST_PRESS_WAIT;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_pressed) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = 4'd0;
                        end else if (r_cnt + 4'd1 >= C_DB) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = C_DB;
                            w_evt       = 1'b1;
                        end else begin
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end
                    ST_HELD: begin
                        if (!w_pressed) begin
                            w_state_nxt = ST_RELEASE_WAIT;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_pressed) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = 4'd0;
                        end else if (r_cnt + 4'd1 >= C_DB) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = C_DB;
                        end else begin
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                endcase
            end

            assign w_key_evt[k] = w_evt;
        end
    endgenerate

`ifdef ZONE_DEBOUNCE_EN
    generate
        for (genvar z = 0; z < 3; z++) begin : g_zone
            logic [3:0] r_zcnt;
            logic       r_db;

            // Any sample matching the current level restarts the count.
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    r_zcnt <= 4'd0;
                    r_db   <= 1'b0;
                end else if (r_zone_s2[z] != r_db) begin
                    if (r_zcnt + 4'd1 >= C_DB) begin
                        r_db   <= r_zone_s2[z];
                        r_zcnt <= 4'd0;
                    end else begin
                        r_zcnt <= r_zcnt + 4'd1;
                    end
                end else begin
                    r_zcnt <= 4'd0;
                end
            end

            assign w_zone_next[z] = r_db;
        end
    endgenerate
`else
    assign w_zone_next = r_zone_s2;
`endif

    // Panic wins a same-cycle tie; the arm FSM still advances to HELD.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_panic_key <= 1'b0;
            r_arm_key   <= 1'b0;
            r_zone_out  <= 3'b000;
        end else begin
            r_panic_key <= w_key_evt[0];
            r_arm_key   <= w_key_evt[1] & ~w_key_evt[0];
            r_zone_out  <= w_zone_next;
        end
    end

    assign panic_key   = r_panic_key;
    assign arm_key     = r_arm_key;
    assign zone_sensor = r_zone_out;

endmodule
`default_nettype wire

// File: tb/tb_alarm_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_input_conditioner
// Description : Self-checking bench: run-length behavioural model compared
//               every cycle, plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_input_conditioner;

    localparam int DB = 3;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iKEY_PANIC = 1'b1;
    logic       iKEY_ARM = 1'b1;
    logic [2:0] iZONE = 3'b000;
    logic       panic_key, arm_key;
    logic [2:0] zone_sensor;

    int checks = 0;
    int failures = 0;

    alarm_input_conditioner #(.DB_CYCLES(DB)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iKEY_PANIC  (iKEY_PANIC),
        .iKEY_ARM    (iKEY_ARM),
        .iZONE       (iZONE),
        .panic_key   (panic_key),
        .arm_key     (arm_key),
        .zone_sensor (zone_sensor)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A key is accepted as changed after DB+1 consecutive opposite synced
    // samples; zones (debounced build) after DB samples, shown one cycle later.
    int         ecnt = 0;
    bit         m_valid = 1'b0;
    logic [1:0] m_kd1, m_kd2;
    logic [2:0] m_zd1, m_zd2;
    bit         m_lvl [2];
    int         m_run [2];
    logic       m_panic, m_arm;
    logic [2:0] m_zone;
    logic [2:0] m_zlvl;
    int         m_zrun [3];

    always @(posedge iCLK) begin
        logic [1:0] ks;
        logic [2:0] zs;
        bit         ev [2];
        bit         pr;
        ecnt++;
        if (iRST) begin
            m_valid = 1'b1;
            m_kd1 = 2'b11; m_kd2 = 2'b11;
            m_zd1 = 3'b000; m_zd2 = 3'b000;
            m_panic = 1'b0; m_arm = 1'b0; m_zone = 3'b000; m_zlvl = 3'b000;
            for (int k = 0; k < 2; k++) begin m_lvl[k] = 1'b0; m_run[k] = 0; end
            for (int z = 0; z < 3; z++) m_zrun[z] = 0;
        end else begin
            ks = m_kd2; m_kd2 = m_kd1; m_kd1 = {iKEY_ARM, iKEY_PANIC};
            zs = m_zd2; m_zd2 = m_zd1; m_zd1 = iZONE;
            for (int k = 0; k < 2; k++) begin
                pr = ~ks[k];
                ev[k] = 1'b0;
                if (pr != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB + 1) begin
                        m_lvl[k] = pr;
                        m_run[k] = 0;
                        ev[k] = pr;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_panic = ev[0];
            m_arm   = ev[1] && !ev[0];
`ifdef ZONE_DEBOUNCE_EN
            m_zone = m_zlvl;
            for (int z = 0; z < 3; z++) begin
                if (zs[z] != m_zlvl[z]) begin
                    m_zrun[z]++;
                    if (m_zrun[z] == DB) begin
                        m_zlvl[z] = zs[z];
                        m_zrun[z] = 0;
                    end
                end else begin
                    m_zrun[z] = 0;
                end
            end
`else
            m_zone = zs;
`endif
        end
    end

    // ---------------- compare + scenario monitor ----------------
    int         base = 0;
    bit         scn_on = 1'b0;
    int         pcnt, acnt, pfirst, afirst, alast, zfirst, zbad, zwin_lo, zwin_hi;
    logic [2:0] ztarget;

    always @(negedge iCLK) begin
        int rel;
        if (m_valid) begin
            chk("model_panic_key", 32'(panic_key), 32'(m_panic));
            chk("model_arm_key", 32'(arm_key), 32'(m_arm));
            chk("model_zone_sensor", 32'(zone_sensor), 32'(m_zone));
            if (panic_key && arm_key) chk("keys_exclusive", 32'd1, 32'd0);
        end
        if (scn_on) begin
            rel = ecnt - base;
            if (panic_key) begin pcnt++; if (pfirst < 0) pfirst = rel; end
            if (arm_key) begin acnt++; if (afirst < 0) afirst = rel; alast = rel; end
            if (zone_sensor == ztarget && zfirst < 0) zfirst = rel;
            if (rel >= zwin_lo && rel <= zwin_hi && zone_sensor != ztarget) zbad++;
        end
    end

    task automatic start_scn();
        @(negedge iCLK);
        iRST = 1'b1; iKEY_PANIC = 1'b1; iKEY_ARM = 1'b1; iZONE = 3'b000;
        @(posedge iCLK);
        #1;
        base = ecnt;
        pcnt = 0; acnt = 0; pfirst = -1; afirst = -1; alast = -1;
        zfirst = -1; zbad = 0; zwin_lo = 1000; zwin_hi = -1; ztarget = 3'b111;
        scn_on = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        chk("reset_panic_key", 32'(panic_key), 32'd0);
        chk("reset_arm_key", 32'(arm_key), 32'd0);
        chk("reset_zone_sensor", 32'(zone_sensor), 32'd0);
    endtask

    // Returns in the negedge phase after edge k (relative to the reset edge).
    task automatic go_to(input int k);
        while (ecnt - base < k) @(negedge iCLK);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arm held 20 cycles from edge 10: one pulse after edge 15.
        start_scn();
        go_to(9);  iKEY_ARM = 1'b0;
        go_to(29); iKEY_ARM = 1'b1;
        go_to(45);
        chk("s1_arm_first", afirst, 15);
        chk("s1_arm_count", acnt, 1);
        chk("s1_panic_count", pcnt, 0);

        // Bouncing panic key: no pulse.
        start_scn();
        go_to(9);  iKEY_PANIC = 1'b0;
        go_to(11); iKEY_PANIC = 1'b1;
        go_to(12); iKEY_PANIC = 1'b0;
        go_to(14); iKEY_PANIC = 1'b1;
        go_to(30);
        chk("s2_panic_count", pcnt, 0);

        // Simultaneous press: panic wins, arm dropped.
        start_scn();
        go_to(9);  iKEY_PANIC = 1'b0; iKEY_ARM = 1'b0;
        go_to(30);
        chk("s3_panic_first", pfirst, 15);
        chk("s3_panic_count", pcnt, 1);
        chk("s3_arm_count", acnt, 0);

        // Reset mid-debounce with arm held: pulse only after edge 20.
        start_scn();
        go_to(9);  iKEY_ARM = 1'b0;
        go_to(13); iRST = 1'b1;
        go_to(14); iRST = 1'b0;
        go_to(35);
        chk("s4_arm_first", afirst, 20);
        chk("s4_arm_count", acnt, 1);

        // Short release bounce keeps HELD; full release then re-press pulses again.
        start_scn();
        go_to(9);  iKEY_ARM = 1'b0;
        go_to(19); iKEY_ARM = 1'b1;
        go_to(22); iKEY_ARM = 1'b0;
        go_to(29); iKEY_ARM = 1'b1;
        go_to(33); iKEY_ARM = 1'b0;
        go_to(45); iKEY_ARM = 1'b1;
        go_to(55);
        chk("s6_arm_count", acnt, 2);
        chk("s6_arm_first", afirst, 15);
        chk("s6_arm_last", alast, 39);

        // Zone conditioning.
        start_scn();
`ifdef ZONE_DEBOUNCE_EN
        ztarget = 3'b010; zwin_lo = 15; zwin_hi = 30;
        go_to(9);  iZONE = 3'b010;
        go_to(19); iZONE = 3'b011;
        go_to(20); iZONE = 3'b010;
        go_to(32);
        chk("s5_zone_first", zfirst, 15);
        chk("s5_zone_glitch", zbad, 0);
        chk("s5_zone_final", 32'(zone_sensor), 32'd2);
`else
        ztarget = 3'b101; zwin_lo = 12; zwin_hi = 25;
        go_to(9);  iZONE = 3'b101;
        go_to(25);
        chk("s5_zone_first", zfirst, 12);
        chk("s5_zone_hold", zbad, 0);
        chk("s5_zone_final", 32'(zone_sensor), 32'd5);
`endif
        scn_on = 1'b0;
        go_to(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_input_conditioner.md
ALARM_INPUT_CONDITIONER -- requirements
Module: alarm_input_conditioner

Interface
REQ-001 Parameter: DB_CYCLES, default 3, consecutive stable synchronised samples required to accept a level change; legal range 1..15.
REQ-002 Port: iCLK  input  1  system clock, one 100 ms tick per cycle; all logic rising-edge on iCLK.
REQ-003 Port: iRST  input  1  synchronous, active-high reset.
REQ-004 Port: iKEY_PANIC  input  1  raw panic push button, active-low, asynchronous to iCLK.
REQ-005 Port: iKEY_ARM  input  1  raw arm push button, active-low, asynchronous to iCLK.
REQ-006 Port: iZONE  input  3  raw zone sensor switches, active-high, asynchronous to iCLK.
REQ-007 Port: panic_key  output  1  single-cycle active-high pulse per accepted panic press.
REQ-008 Port: arm_key  output  1  single-cycle active-high pulse per accepted arm press.
REQ-009 Port: zone_sensor  output  3  conditioned zone levels, active-high, bit i = zone i+1.

Function
REQ-010 Each raw input bit SHALL pass through a two-flop synchroniser before any other logic.
REQ-011 Each key SHALL have an independent FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-012 IDLE -> PRESS_WAIT when synced key reads pressed (0); debounce counter cleared to 0.
REQ-013 PRESS_WAIT: counter increments each cycle key reads pressed; any released sample -> IDLE, counter cleared.
REQ-014 PRESS_WAIT -> HELD when counter reaches DB_CYCLES; key pulse asserted for exactly the first cycle in HELD.
REQ-015 Timing: press first sampled at edge E0 and held stable -> pulse high during cycle after edge E0+DB_CYCLES+2.
REQ-016 HELD: no further pulses regardless of hold duration; released sample -> RELEASE_WAIT, counter cleared.
REQ-017 RELEASE_WAIT: counter increments on released samples; pressed sample -> HELD without pulse; counter reaching DB_CYCLES -> IDLE.
REQ-018 Counters SHALL be 4 bits, saturate at DB_CYCLES, never wrap.
REQ-019 Simultaneous event: if panic and arm pulses would assert in the same cycle, panic_key SHALL assert and the arm pulse SHALL be dropped (arm FSM still enters HELD).
REQ-020 panic_key and arm_key SHALL never be high in the same cycle.
REQ-021 Outputs SHALL be registered; no combinational path from any input port to any output.

Reset
REQ-022 iRST high at an iCLK edge: both key FSMs -> IDLE, counters 0, synchroniser flops for keys -> 1 (released), zone synchroniser flops -> 0.
REQ-023 Reset values: panic_key 0, arm_key 0, zone_sensor 3'b000.
REQ-024 Reset mid-debounce or mid-hold SHALL discard progress; a key held through reset release SHALL produce a pulse only after full REQ-015 latency measured from first post-reset edge.

Configuration
REQ-025 Macro ZONE_DEBOUNCE_EN defined: each zone_sensor bit changes only after DB_CYCLES consecutive synced samples differing from its current output value; a differing-then-matching sample restarts that bit's count.
REQ-026 Macro ZONE_DEBOUNCE_EN undefined: zone_sensor equals synchronised iZONE registered once (3-cycle latency), no zone counters built.
REQ-027 Key debouncing SHALL be identical with or without the macro.

Verification (DB_CYCLES=3)
REQ-028 iKEY_ARM held 0 from edge 10 for 20 cycles -> arm_key high only in cycle after edge 15; no further pulse.
REQ-029 iKEY_PANIC low for 2 cycles, high 1, low 2 (bounce) then high -> no panic_key pulse.
REQ-030 Both keys driven 0 at edge 10, held -> panic_key pulse after edge 15, arm_key stays 0 throughout.
REQ-031 iKEY_ARM held 0, iRST pulsed at edge 14 for 1 cycle -> no pulse at 15; pulse after edge 20.
REQ-032 ZONE_DEBOUNCE_EN defined: iZONE=3'b010 at edge 10 held -> zone_sensor=3'b010 from cycle after edge 15; 1-cycle glitch on bit 0 -> zone_sensor unchanged.
REQ-033 ZONE_DEBOUNCE_EN undefined: iZONE=3'b101 at edge 10 -> zone_sensor=3'b101 from cycle after edge 12.
